// File: rtl/fb_draw_writer_pkg.sv
// fb_draw_writer_pkg: shared state encoding and framebuffer sizing helper.
package fb_draw_writer_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, START, DRAW, DONE} state_t;

    function automatic int fb_pixels(input int width, input int height);
        return width * height;
    endfunction
endpackage

// File: rtl/fb_draw_writer_if.sv
// fb_draw_writer_if: renderer pixel stream, sequence control and framebuffer write port.
interface fb_draw_writer_if
    import fb_draw_writer_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int CIDXW = 4,
    parameter int FB_ADDRW = $clog2(fb_pixels(320, 180))
);
    logic frame_start;
    logic [CIDXW-1:0] bg_cidx;
    logic render_start;
    logic render_oe;
    logic signed [CORDW-1:0] px;
    logic signed [CORDW-1:0] py;
    logic [CIDXW-1:0] pcidx;
    logic pdrawing;
    logic render_done;
    logic mem_ready;
    logic fb_we;
    logic [FB_ADDRW-1:0] fb_addr;
    logic [CIDXW-1:0] fb_cidx;
    logic busy;
    logic done;

    modport master (
        input frame_start, bg_cidx, px, py, pcidx, pdrawing, render_done, mem_ready,
        output render_start, render_oe, fb_we, fb_addr, fb_cidx, busy, done
    );
    modport slave (
        output frame_start, bg_cidx, px, py, pcidx, pdrawing, render_done, mem_ready,
        input render_start, render_oe, fb_we, fb_addr, fb_cidx, busy, done
    );
endinterface

// File: rtl/fb_clip_addr.sv
// fb_clip_addr: registered clip test and y*width+x address for one pixel, stalled by en.
module fb_clip_addr #(
    parameter int CORDW = 16,
    parameter int CIDXW = 4,
    parameter int FB_WIDTH = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FB_ADDRW = 16
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic valid,
    input logic signed [CORDW-1:0] x,
    input logic signed [CORDW-1:0] y,
    input logic [CIDXW-1:0] cidx,
    output logic out_valid,
    output logic out_hit,
    output logic [FB_ADDRW-1:0] out_addr,
    output logic [CIDXW-1:0] out_cidx
);
    localparam int PW = CORDW + FB_ADDRW;
    logic hit;
    logic [FB_ADDRW-1:0] addr;

    assign hit = int'(x) >= 0 && int'(x) < FB_WIDTH && int'(y) >= 0 && int'(y) < FB_HEIGHT;
    assign addr = FB_ADDRW'(PW'($unsigned(y)) * PW'(FB_WIDTH) + PW'($unsigned(x)));

    always_ff @(posedge clk)
        if (rst) begin
            out_valid <= 1'b0;
            out_hit <= 1'b0;
            out_addr <= '0;
            out_cidx <= '0;
        end else if (en) begin
            out_valid <= valid;
            out_hit <= hit;
            out_addr <= addr;
            out_cidx <= cidx;
        end
endmodule

// File: rtl/fb_draw_writer.sv
// fb_draw_writer: clears the framebuffer, starts a renderer and writes its clipped pixels.
// Clear phase is built only when FB_DRAW_WRITER_CLEAR_EN is defined.
module fb_draw_writer
    import fb_draw_writer_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int CIDXW = 4,
    parameter int FB_WIDTH = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FB_ADDRW = $clog2(fb_pixels(FB_WIDTH, FB_HEIGHT))
) (
    input logic clk,
    input logic rst,
    fb_draw_writer_if.master bus
);
    localparam logic [FB_ADDRW-1:0] LAST = FB_ADDRW'(fb_pixels(FB_WIDTH, FB_HEIGHT) - 1);
    state_t st, nxt;
    logic [FB_ADDRW-1:0] clr, a1, a2;
    logic [CIDXW-1:0] bg_q, c1, c2;
    logic acc, v1, hit1, we2, seen, empty;

    assign acc = st == DRAW && bus.mem_ready && bus.pdrawing;
    // Stage 2 counts as empty when its write retires this cycle.
    assign empty = !acc && !v1 && (!we2 || bus.mem_ready);

    fb_clip_addr #(
        .CORDW(CORDW), .CIDXW(CIDXW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .FB_ADDRW(FB_ADDRW)
    ) u_clip (
        .clk(clk), .rst(rst), .en(bus.mem_ready), .valid(acc),
        .x(bus.px), .y(bus.py), .cidx(bus.pcidx),
        .out_valid(v1), .out_hit(hit1), .out_addr(a1), .out_cidx(c1)
    );

    always_ff @(posedge clk)
        if (rst) begin
            we2 <= 1'b0;
            a2 <= '0;
            c2 <= '0;
        end else if (bus.mem_ready) begin
            we2 <= v1 && hit1;
            a2 <= a1;
            c2 <= c1;
        end

    always_ff @(posedge clk) seen <= !rst && st == DRAW && (seen || bus.render_done);

`ifdef FB_DRAW_WRITER_CLEAR_EN
    localparam state_t FIRST = CLEAR;
    always_ff @(posedge clk) begin
        clr <= (rst || st != CLEAR) ? '0 : clr + FB_ADDRW'(bus.mem_ready);
        if (rst) bg_q <= '0;
        else if (st == IDLE && bus.frame_start) bg_q <= bus.bg_cidx;
    end
`else
    localparam state_t FIRST = START;
    assign clr = '0;
    assign bg_q = '0;
`endif

    always_ff @(posedge clk) st <= rst ? IDLE : nxt;

    always_comb begin
        nxt = st;
        case (st)
            IDLE: nxt = bus.frame_start ? FIRST : IDLE;
            CLEAR: nxt = bus.mem_ready && clr == LAST ? START : CLEAR;
            START: nxt = DRAW;
            DRAW: nxt = (seen || bus.render_done) && empty ? DONE : DRAW;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.render_start = st == START;
        bus.render_oe = st == DRAW && bus.mem_ready;
        bus.busy = st != IDLE;
        bus.done = st == DONE;
        bus.fb_we = bus.mem_ready && (st == CLEAR || we2);
        bus.fb_addr = st == CLEAR ? clr : a2;
        bus.fb_cidx = st == CLEAR ? bg_q : c2;
    end
endmodule

// File: tb/tb_fb_draw_writer.sv
// tb_fb_draw_writer: directed timing steps plus randomized frames checked against a write-list model.
module tb_fb_draw_writer;
    localparam int W = 4, H = 2;
`ifdef FB_DRAW_WRITER_CLEAR_EN
    localparam int E = W * H;
`else
    localparam int E = 0;
`endif
    logic clk = 0, rst = 1;
    logic [3:0] bgd = 0;
    int checks = 0, errors = 0;
    int lx[$], ly[$], lc[$];

    fb_draw_writer_if #(.CORDW(16), .CIDXW(4), .FB_ADDRW(3)) bus ();
    fb_draw_writer #(.CORDW(16), .CIDXW(4), .FB_WIDTH(W), .FB_HEIGHT(H), .FB_ADDRW(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input bit fs, input bit mr, input bit pd, input int x = 0, input int y = 0,
                       input int c = 0, input bit rd = 0);
        @(posedge clk);
        #1;
        bus.frame_start = fs;
        bus.mem_ready = mr;
        bus.pdrawing = pd;
        bus.px = 16'(x);
        bus.py = 16'(y);
        bus.pcidx = 4'(c);
        bus.render_done = rd;
        bus.bg_cidx = bgd;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [3:0] bg, input bit with_last, input int stall);
        int idx = 0, n = lx.size(), cyc_n = 0, acc_cyc = -1, done_cyc = -1, bad_we = 0, idle_seen = 0;
        bit started = 0, acc = 0, sent = 0, pd = 0, mr = 0;
        logic [6:0] exp_q[$], got_q[$];
        for (int a = 0; a < E; a++) exp_q.push_back({3'(a), bg});
        for (int i = 0; i < n; i++)
            if (lx[i] >= 0 && lx[i] < W && ly[i] >= 0 && ly[i] < H)
                exp_q.push_back({3'(ly[i] * W + lx[i]), 4'(lc[i])});
        bgd = bg;
        cyc(1, 1, 0);
        bgd = ~bg;
        while (done_cyc < 0 && cyc_n < 3000) begin
            mr = $urandom_range(99) >= stall;
            pd = started && idx < n;
            cyc($urandom_range(9) == 0, mr, pd, pd ? lx[idx] : 0, pd ? ly[idx] : 0, pd ? lc[idx] : 0, 0);
            cyc_n++;
            acc = bus.render_oe && bus.pdrawing;
            if (started && !sent && (with_last ? acc && idx == n - 1 : idx == n)) begin
                bus.render_done = 1;
                sent = 1;
            end
            if (acc) begin
                idx++;
                acc_cyc = cyc_n;
            end
            if (bus.fb_we) got_q.push_back({bus.fb_addr, bus.fb_cidx});
            if (bus.fb_we && !bus.mem_ready) bad_we++;
            if (!bus.busy) idle_seen++;
            if (bus.render_start) started = 1;
            if (bus.done) done_cyc = cyc_n;
        end
        chk("frame_timeout", 32'(done_cyc >= 0), 1);
        chk("pixels_consumed", idx, n);
        chk("we_while_stalled", bad_we, 0);
        chk("busy_during_frame", idle_seen, 0);
        chk("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("write_entry", got_q[i], exp_q[i]);
        if (with_last && stall == 0) chk("done_latency", done_cyc - acc_cyc, 3);
        cyc(0, 1, 0);
        chk("done_single", bus.done, 0);
        chk("busy_after", bus.busy, 0);
    endtask

    task automatic rand_pixels(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            lx.push_back(int'($urandom_range(hi - lo)) + lo);
            ly.push_back(int'($urandom_range(hi - lo)) + lo);
            lc.push_back(int'($urandom_range(15)));
        end
    endtask

    initial begin
        bus.frame_start = 0;
        bus.bg_cidx = 0;
        bus.px = 0;
        bus.py = 0;
        bus.pcidx = 0;
        bus.pdrawing = 0;
        bus.render_done = 0;
        bus.mem_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        cyc(0, 1, 0);
        chk("rst_render_start", bus.render_start, 0);
        chk("rst_render_oe", bus.render_oe, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_cidx", bus.fb_cidx, 0);

        bgd = 3;
        cyc(1, 1, 0);
        chk("idle_busy", bus.busy, 0);
        bgd = 7;
        for (int k = 1; k <= E; k++) begin
            if (k == 5)
                repeat (2) begin
                    cyc(0, 0, 0);
                    chk("clear_stall_we", bus.fb_we, 0);
                    chk("clear_stall_addr", bus.fb_addr, 4);
                end
            cyc(k == 3, 1, 0);
            chk("clear_we", bus.fb_we, 1);
            chk("clear_addr", bus.fb_addr, k - 1);
            chk("clear_cidx", bus.fb_cidx, 3);
        end
        cyc(1, 1, 0);
        chk("start_pulse", bus.render_start, 1);
        chk("start_no_we", bus.fb_we, 0);
        cyc(0, 1, 1, 2, 1, 9);
        chk("start_once", bus.render_start, 0);
        chk("draw_oe", bus.render_oe, 1);
        cyc(0, 1, 1, 1, 0, 5);
        chk("stage1_no_we", bus.fb_we, 0);
        cyc(0, 1, 0);
        chk("px_we", bus.fb_we, 1);
        chk("px_addr", bus.fb_addr, 6);
        chk("px_cidx", bus.fb_cidx, 9);
        repeat (3) begin
            cyc(0, 0, 1, 3, 1, 12);
            chk("stall_oe", bus.render_oe, 0);
            chk("stall_we", bus.fb_we, 0);
            chk("stall_addr", bus.fb_addr, 1);
            chk("stall_cidx", bus.fb_cidx, 5);
        end
        cyc(0, 1, 1, 3, 1, 12);
        chk("resume_we", bus.fb_we, 1);
        chk("resume_addr", bus.fb_addr, 1);
        chk("resume_cidx", bus.fb_cidx, 5);
        cyc(0, 1, 1, -1, 0, 2);
        chk("after_resume_we", bus.fb_we, 0);
        cyc(0, 1, 1, 4, 0, 2);
        chk("px3_addr", bus.fb_addr, 7);
        chk("px3_cidx", bus.fb_cidx, 12);
        cyc(0, 1, 1, 0, 2, 2, 1);
        chk("clip_x_neg", bus.fb_we, 0);
        cyc(0, 1, 0);
        chk("clip_x_wide", bus.fb_we, 0);
        chk("not_done_yet", bus.done, 0);
        cyc(0, 1, 0);
        chk("clip_y_high", bus.fb_we, 0);
        cyc(0, 1, 0);
        chk("done_pulse", bus.done, 1);
        chk("busy_with_done", bus.busy, 1);
        cyc(0, 1, 0);
        chk("done_fall", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
        cyc(0, 1, 0);
        chk("no_restart", bus.busy, 0);

        cyc(1, 1, 0);
        repeat (4) cyc(0, 1, 0);
        rst = 1;
        cyc(0, 1, 0);
        chk("abort_we", bus.fb_we, 0);
        chk("abort_busy", bus.busy, 0);
        rst = 0;
        bgd = 5;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
`ifdef FB_DRAW_WRITER_CLEAR_EN
        chk("restart_we", bus.fb_we, 1);
        chk("restart_addr", bus.fb_addr, 0);
        chk("restart_cidx", bus.fb_cidx, 5);
`else
        chk("restart_start", bus.render_start, 1);
`endif
        rst = 1;
        cyc(0, 1, 0);
        rst = 0;
        cyc(0, 1, 0);

        lx = '{-1, 4, 0};
        ly = '{0, 0, 2};
        lc = '{1, 2, 3};
        rand_pixels(6, -2, 5);
        run_frame(4'($urandom_range(15)), 0, 30);
        lx.delete();
        ly.delete();
        lc.delete();
        rand_pixels(12, -1, 4);
        run_frame(4'($urandom_range(15)), 1, 0);
        lx.delete();
        ly.delete();
        lc.delete();
        rand_pixels(10, -2, 5);
        run_frame(4'($urandom_range(15)), 1, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
